// File: rtl/cam_core_if.sv
// CAM request/response bus between the test side (master) and the CAM (slave).
interface cam_core_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 2
);
    logic                  writ_enable;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  cmp_start;
    logic [DATA_WIDTH-1:0] cmp_din;
    logic                  busy;
    logic                  match;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic                  done;

    modport master (
        output writ_enable, wr_addr, data_in, cmp_start, cmp_din,
        input  busy, match, match_addr, done
    );

    modport slave (
        input  writ_enable, wr_addr, data_in, cmp_start, cmp_din,
        output busy, match, match_addr, done
    );
endinterface

// File: rtl/cam_core.sv
// Sequential-scan CAM: addressed writes, one entry per clock compare, lowest hit wins.
module cam_core #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    cam_core_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

    typedef enum logic {StIdle, StScan} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  busy_q;
    logic                  match_q;
    logic [ADDR_WIDTH-1:0] match_addr_q;
    logic                  done_q;
    logic                  wr_accept;
    logic                  hit;

    assign wr_accept = bus.writ_enable && (state_q == StIdle);
    assign hit       = valid_q[idx_q] && (mem[idx_q] == key_q);

    // Array payload carries no reset; only the valid bits gate matching.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[bus.wr_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            key_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            match_q      <= 1'b0;
            match_addr_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A write in the same cycle as a compare request wins; the request is dropped.
                    if (bus.writ_enable) begin
                        valid_q[bus.wr_addr] <= 1'b1;
                    end else if (bus.cmp_start) begin
                        key_q        <= bus.cmp_din;
                        idx_q        <= '0;
                        match_q      <= 1'b0;
                        match_addr_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= StScan;
                    end
                end
                StScan: begin
                    if (hit) begin
                        match_q      <= 1'b1;
                        match_addr_q <= idx_q;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                    end else if (idx_q == LastIdx) begin
                        match_q      <= 1'b0;
                        match_addr_q <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.match      = match_q;
    assign bus.match_addr = match_addr_q;
    assign bus.done       = done_q;
endmodule
